// File: rtl/spi_reg_bank.sv
// SPI register bank: rw + address + data frames, MSB first, resynchronised into clk.
// Writes commit on nCS rise after exactly FRAME bits; reads shift out on the falling sCLK edges.
module spi_reg_bank #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sCLK,
  input  logic                       nCS,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0] C_FRAME     = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] C_SAT       = CNT_W'(FRAME + 1);
  localparam logic [CNT_W-1:0] C_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] C_DATA_LO   = CNT_W'(1 + ADDR_W);
  localparam logic [ADDR_W:0]  C_NREGS     = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA_WR, S_DATA_RD} state_t;
  state_t r_state, w_state_nxt;

  logic [2:0]        r_sclk_sync, r_ncs_sync;
  logic [1:0]        r_copi_sync;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr, r_wr_addr;
  logic [DATA_W-1:0] r_data, r_rd_sr, w_rd_val;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_wr_strobe, r_frame_err;
  logic              w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall;
  logic              w_sclk_rise_v, w_sclk_fall_v, w_copi, w_commit, w_oe;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  // Stage [1] is the synchronised level, stage [2] the one-clk-delayed copy for edge detection.
  assign w_sclk_rise   = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall   = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_ncs_rise    = r_ncs_sync[1] & ~r_ncs_sync[2];
  assign w_ncs_fall    = ~r_ncs_sync[1] & r_ncs_sync[2];
  assign w_sclk_rise_v = w_sclk_rise & ~r_ncs_sync[1];
  assign w_sclk_fall_v = w_sclk_fall & ~r_ncs_sync[1];
  assign w_copi        = r_copi_sync[1];
  assign w_addr_nxt    = ADDR_W'({r_addr, w_copi});
  assign w_data_nxt    = DATA_W'({r_data, w_copi});
  assign w_commit      = w_ncs_rise && (r_cnt == C_FRAME) && r_rw && ({1'b0, r_addr} < C_NREGS);

  // Unimplemented addresses fall through to zero.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_addr_nxt == ADDR_W'(i)) w_rd_val = r_regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_cnt       <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rd_sr     <= '0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sCLK};
      r_ncs_sync  <= {r_ncs_sync[1:0], nCS};
      r_copi_sync <= {r_copi_sync[0], COPI};
      r_wr_strobe <= w_commit;
      r_frame_err <= w_ncs_rise && (r_cnt != C_FRAME) && (r_cnt != '0);
      if (w_commit) begin
        r_wr_addr <= r_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_addr == ADDR_W'(i)) r_regs[i] <= r_data;
        end
      end
      if (w_ncs_fall) begin
        r_cnt   <= '0;
        r_rw    <= 1'b0;
        r_addr  <= '0;
        r_data  <= '0;
        r_rd_sr <= '0;
      end else if (w_sclk_rise_v) begin
        if (r_cnt != C_SAT) r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == '0) r_rw <= w_copi;
        else if (r_cnt <= C_LAST_ADDR) r_addr <= w_addr_nxt;
        else if (r_cnt < C_FRAME) r_data <= w_data_nxt;
        if (r_cnt == C_LAST_ADDR) r_rd_sr <= w_rd_val;
      end else if (w_sclk_fall_v && (r_cnt > C_DATA_LO) && (r_cnt < C_FRAME)) begin
        r_rd_sr <= r_rd_sr << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_ncs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_ncs_fall) w_state_nxt = S_CMD;
        S_CMD:   if (w_sclk_rise_v) w_state_nxt = S_ADDR;
        S_ADDR:  if (w_sclk_rise_v && (r_cnt == C_LAST_ADDR)) w_state_nxt = r_rw ? S_DATA_WR : S_DATA_RD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_oe    = (r_state == S_DATA_RD);
    cipo_oe = w_oe;
    CIPO    = w_oe & r_rd_sr[DATA_W-1];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: default instance (A) and a 4/16/3 instance (B) sharing sCLK/COPI.
// A register-array model tracks expected contents; frames are driven at SPI pin level.
module tb_spi_reg_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0, copi = 1'b0, ncs_a = 1'b1, ncs_b = 1'b1;
  logic cipo_a, oe_a, wrs_a, ferr_a;
  logic cipo_b, oe_b, wrs_b, ferr_b;
  logic [39:0] regs_a;
  logic [47:0] regs_b;
  logic [6:0]  wra_a;
  logic [3:0]  wra_b;
  int errors = 0;
  int checks = 0;
  int n_wrs [2];
  int n_ferr [2];
  logic [15:0] mdl [2][5];

  always #5 clk = ~clk;

  spi_reg_bank u_a (
    .clk(clk), .rst(rst), .sCLK(sclk), .nCS(ncs_a), .COPI(copi), .CIPO(cipo_a), .cipo_oe(oe_a),
    .regs_flat(regs_a), .wr_strobe(wrs_a), .wr_addr(wra_a), .frame_err(ferr_a));

  spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(3)) u_b (
    .clk(clk), .rst(rst), .sCLK(sclk), .nCS(ncs_b), .COPI(copi), .CIPO(cipo_b), .cipo_oe(oe_b),
    .regs_flat(regs_b), .wr_strobe(wrs_b), .wr_addr(wra_b), .frame_err(ferr_b));

  initial begin
    n_wrs[0] = 0; n_wrs[1] = 0; n_ferr[0] = 0; n_ferr[1] = 0;
  end

  always @(negedge clk) begin
    if (wrs_a)  n_wrs[0]  = n_wrs[0] + 1;
    if (wrs_b)  n_wrs[1]  = n_wrs[1] + 1;
    if (ferr_a) n_ferr[0] = n_ferr[0] + 1;
    if (ferr_b) n_ferr[1] = n_ferr[1] + 1;
  end

  function automatic int aw(input int d); return (d == 0) ? 7 : 4;  endfunction
  function automatic int dw(input int d); return (d == 0) ? 8 : 16; endfunction
  function automatic int nr(input int d); return (d == 0) ? 5 : 3;  endfunction
  function automatic int fr(input int d); return 1 + aw(d) + dw(d); endfunction

  function automatic logic [63:0] cur_flat(input int d);
    return (d == 0) ? {24'b0, regs_a} : {16'b0, regs_b};
  endfunction

  function automatic logic [63:0] model_flat(input int d);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < nr(d); i++)
      for (int b = 0; b < dw(d); b++) f[i*dw(d)+b] = mdl[d][i][b];
    return f;
  endfunction

  function automatic logic [63:0] mkframe(input int d, input logic rw, input int addr, input int data, input int nbits);
    logic [63:0] v;
    v = (64'(rw) << (aw(d) + dw(d))) | (64'(addr) << dw(d)) | 64'(data);
    if (nbits < fr(d)) v = v >> (fr(d) - nbits);
    else if (nbits > fr(d)) v = (v << (nbits - fr(d))) | (64'($urandom) & ((64'd1 << (nbits - fr(d))) - 64'd1));
    return v;
  endfunction

  task automatic set_ncs(input int d, input logic v);
    if (d == 0) ncs_a = v; else ncs_b = v;
  endtask

  // One SPI bit: read data is sampled just before the controller's rising edge.
  task automatic spi_bit(input int d, input logic b, output logic rx, output logic oe);
    copi = b;
    repeat (3) @(negedge clk);
    rx = (d == 0) ? cipo_a : cipo_b;
    oe = (d == 0) ? oe_a : oe_b;
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic spi_end(input int d, output logic [63:0] pre, output logic [63:0] post,
                         output logic strb, output logic ferr, output int wa);
    repeat (3) @(negedge clk);
    set_ncs(d, 1'b1);
    repeat (2) @(negedge clk);
    pre = cur_flat(d);
    @(negedge clk);
    post = cur_flat(d);
    strb = (d == 0) ? wrs_a : wrs_b;
    ferr = (d == 0) ? ferr_a : ferr_b;
    wa   = (d == 0) ? int'(wra_a) : int'(wra_b);
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_xfer(input int d, input logic [63:0] bits, input int nbits,
                          output logic [63:0] rx, output logic [63:0] oe, output logic [63:0] pre,
                          output logic [63:0] post, output logic strb, output logic ferr, output int wa);
    logic r, o;
    rx = '0;
    oe = '0;
    set_ncs(d, 1'b0);
    repeat (6) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(d, bits[i], r, o);
      rx[i] = r;
      oe[i] = o;
    end
    spi_end(d, pre, post, strb, ferr, wa);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    checks++; if (regs_a !== 40'h0) begin errors++; $display("FAIL reset_regs_a: got %h want 0", regs_a); end
    checks++; if (regs_b !== 48'h0) begin errors++; $display("FAIL reset_regs_b: got %h want 0", regs_b); end
    checks++; if ({wrs_a, ferr_a, oe_a, cipo_a} !== 4'b0) begin errors++; $display("FAIL reset_flags_a: got %b want 0000", {wrs_a, ferr_a, oe_a, cipo_a}); end
    checks++; if ({wrs_b, ferr_b, oe_b, cipo_b} !== 4'b0) begin errors++; $display("FAIL reset_flags_b: got %b want 0000", {wrs_b, ferr_b, oe_b, cipo_b}); end
    checks++; if ({wra_a, wra_b} !== 11'h0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", {wra_a, wra_b}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [63:0] rx, oe, pre, post;
    logic strb, ferr;
    int wa, c0;
    c0 = n_wrs[0];
    spi_xfer(0, 64'h84A5, 16, rx, oe, pre, post, strb, ferr, wa);
    checks++; if (pre !== model_flat(0)) begin errors++; $display("FAIL wr_early: got %h want %h", pre, model_flat(0)); end
    mdl[0][4] = 16'hA5;
    checks++; if (post[39:32] !== 8'hA5) begin errors++; $display("FAIL wr_reg4: got %h want a5", post[39:32]); end
    checks++; if (strb !== 1'b1 || wa != 4) begin errors++; $display("FAIL wr_strobe_addr: got %b/%0d want 1/4", strb, wa); end
    checks++; if (n_wrs[0] - c0 != 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", n_wrs[0] - c0); end
    spi_xfer(0, 64'h0400 | 64'($urandom_range(0, 255)), 16, rx, oe, pre, post, strb, ferr, wa);
    checks++; if (rx[7:0] !== 8'hA5) begin errors++; $display("FAIL rd_reg4: got %h want a5", rx[7:0]); end
    checks++; if (oe[15:0] !== 16'h00FF) begin errors++; $display("FAIL rd_oe: got %h want 00ff", oe[15:0]); end
    checks++; if (post !== model_flat(0) || strb !== 1'b0 || ferr !== 1'b0) begin errors++; $display("FAIL rd_side_effect: got %h/%b/%b want %h/0/0", post, strb, ferr, model_flat(0)); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rx, oe, pre, post;
    logic strb, ferr;
    int wa, c0, e0;
    c0 = n_wrs[0]; e0 = n_ferr[0];
    spi_xfer(0, 64'h90FF, 16, rx, oe, pre, post, strb, ferr, wa);
    checks++; if (post !== model_flat(0)) begin errors++; $display("FAIL oor_regs: got %h want %h", post, model_flat(0)); end
    checks++; if (n_wrs[0] - c0 != 0 || n_ferr[0] - e0 != 0) begin errors++; $display("FAIL oor_pulses: got %0d/%0d want 0/0", n_wrs[0] - c0, n_ferr[0] - e0); end
    spi_xfer(0, 64'h1000, 16, rx, oe, pre, post, strb, ferr, wa);
    checks++; if (rx[7:0] !== 8'h00 || oe[15:0] !== 16'h00FF) begin errors++; $display("FAIL oor_read: got %h/%h want 00/00ff", rx[7:0], oe[15:0]); end
  endtask

  task automatic test_bad_count();
    logic [63:0] rx, oe, pre, post;
    logic strb, ferr;
    int wa, e0, c0;
    for (int k = 0; k < 3; k++) begin
      int nb;
      nb = (k == 0) ? 15 : (k == 1) ? 17 : 0;
      e0 = n_ferr[0]; c0 = n_wrs[0];
      spi_xfer(0, mkframe(0, 1'b1, 1, 'h3C, nb), nb, rx, oe, pre, post, strb, ferr, wa);
      checks++; if (post[15:8] !== 8'h00) begin errors++; $display("FAIL bad_reg1_n%0d: got %h want 00", nb, post[15:8]); end
      checks++; if (n_ferr[0] - e0 != ((nb != 0) ? 1 : 0) || n_wrs[0] - c0 != 0) begin
        errors++; $display("FAIL bad_pulses_n%0d: ferr %0d wr %0d want %0d/0", nb, n_ferr[0] - e0, n_wrs[0] - c0, (nb != 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_param_b();
    logic [63:0] rx, oe, pre, post;
    logic strb, ferr;
    int wa;
    spi_xfer(1, mkframe(1, 1'b1, 2, 'hBEEF, 21), 21, rx, oe, pre, post, strb, ferr, wa);
    mdl[1][2] = 16'hBEEF;
    checks++; if (post[47:32] !== 16'hBEEF || strb !== 1'b1 || wa != 2) begin errors++; $display("FAIL b_write: got %h/%b/%0d want beef/1/2", post[47:32], strb, wa); end
    spi_xfer(1, mkframe(1, 1'b0, 2, 0, 21), 21, rx, oe, pre, post, strb, ferr, wa);
    checks++; if (rx[15:0] !== 16'hBEEF || oe[20:0] !== 21'h00FFFF) begin errors++; $display("FAIL b_read: got %h/%h want beef/00ffff", rx[15:0], oe[20:0]); end
    checks++; if (post !== model_flat(1)) begin errors++; $display("FAIL b_regs: got %h want %h", post, model_flat(1)); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] fr0, rx, oe, pre, post;
    logic strb, ferr, r, o;
    int wa, e0;
    fr0 = mkframe(0, 1'b1, 0, 'h5A, 16);
    set_ncs(0, 1'b0);
    repeat (6) @(negedge clk);
    for (int i = 15; i >= 6; i--) spi_bit(0, fr0[i], r, o);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (regs_a !== 40'h0 || wra_a !== 7'h0) begin errors++; $display("FAIL rstmid_regs: got %h/%h want 0/0", regs_a, wra_a); end
    checks++; if ({wrs_a, ferr_a, oe_a, cipo_a} !== 4'b0) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", {wrs_a, ferr_a, oe_a, cipo_a}); end
    for (int d = 0; d < 2; d++) for (int i = 0; i < 5; i++) mdl[d][i] = '0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    e0 = n_ferr[0];
    set_ncs(0, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if (n_ferr[0] - e0 != 0 || regs_a !== 40'h0) begin errors++; $display("FAIL rstmid_abort: ferr %0d regs %h want 0/0", n_ferr[0] - e0, regs_a); end
    spi_xfer(0, fr0, 16, rx, oe, pre, post, strb, ferr, wa);
    mdl[0][0] = 16'h5A;
    checks++; if (post !== model_flat(0) || strb !== 1'b1) begin errors++; $display("FAIL rstmid_write: got %h/%b want %h/1", post, strb, model_flat(0)); end
  endtask

  task automatic test_random_frames();
    logic [63:0] rx, oe, pre, post, dmask, exp_oe;
    logic strb, ferr, rw, commit, exp_err;
    logic [15:0] exp_rd;
    int wa, d, addr, data, nb, sel, c0, e0;
    for (int n = 0; n < 40; n++) begin
      d    = int'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, nr(d) + 2));
      dmask = (64'd1 << dw(d)) - 64'd1;
      data = int'(64'($urandom) & dmask);
      sel  = int'($urandom_range(0, 9));
      nb   = (sel == 0) ? fr(d) - 1 : (sel == 1) ? fr(d) + int'($urandom_range(1, 4)) :
             (sel == 2) ? int'($urandom_range(0, fr(d) - 2)) : fr(d);
      commit  = (nb == fr(d)) && rw && (addr < nr(d));
      exp_err = (nb != fr(d)) && (nb != 0);
      exp_rd  = (addr < nr(d)) ? mdl[d][addr] : 16'h0;
      exp_oe  = (!rw && nb == fr(d)) ? dmask : 64'h0;
      c0 = n_wrs[d]; e0 = n_ferr[d];
      spi_xfer(d, mkframe(d, rw, addr, data, nb), nb, rx, oe, pre, post, strb, ferr, wa);
      checks++; if (pre !== model_flat(d)) begin errors++; $display("FAIL rnd%0d_pre: got %h want %h", n, pre, model_flat(d)); end
      if (commit) mdl[d][addr] = 16'(data);
      checks++; if (post !== model_flat(d)) begin errors++; $display("FAIL rnd%0d_regs: got %h want %h", n, post, model_flat(d)); end
      checks++; if (strb !== commit || ferr !== exp_err) begin errors++; $display("FAIL rnd%0d_pulse: got %b/%b want %b/%b", n, strb, ferr, commit, exp_err); end
      checks++; if (n_wrs[d] - c0 != int'(commit) || n_ferr[d] - e0 != int'(exp_err)) begin
        errors++; $display("FAIL rnd%0d_counts: got %0d/%0d want %0d/%0d", n, n_wrs[d] - c0, n_ferr[d] - e0, commit, exp_err);
      end
      if (commit) begin
        checks++; if (wa != addr) begin errors++; $display("FAIL rnd%0d_wr_addr: got %0d want %0d", n, wa, addr); end
      end
      if (nb == fr(d)) begin
        checks++; if (oe !== exp_oe) begin errors++; $display("FAIL rnd%0d_oe: got %h want %h", n, oe, exp_oe); end
        if (!rw) begin
          checks++; if ((rx & dmask) !== 64'(exp_rd)) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", n, rx & dmask, exp_rd); end
        end
      end
      checks++; if ({oe_a, cipo_a, oe_b, cipo_b} !== 4'b0) begin errors++; $display("FAIL rnd%0d_idle_oe: got %b want 0000", n, {oe_a, cipo_a, oe_b, cipo_b}); end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 5; i++) mdl[d][i] = '0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_bad_count();
    test_param_b();
    test_reset_midframe();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
